// File: rtl/iterative_divider.sv
// Restoring 64-bit signed/unsigned divider: one quotient bit per cycle, done pulses WIDTH+3 cycles after start.
// No backpressure: start is accepted only in IDLE, and results hold until the next accepted start.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg, r_reg, dvsr_reg, dvnd_orig;
  logic             neg_dvnd, neg_dvsr;

  logic [WIDTH:0]   r_shift;
  logic             r_ge;
  logic [WIDTH-1:0] r_step, q_fix, r_fix;
  logic             dz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Partial remainder carries one extra bit so divisors above 2^(WIDTH-1) compare correctly.
  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    r_ge    = (r_shift >= {1'b0, dvsr_reg});
    r_step  = r_ge ? (r_shift[WIDTH-1:0] - dvsr_reg) : r_shift[WIDTH-1:0];
    dz      = (dvsr_reg == '0);
    q_fix   = dz ? '1 : ((neg_dvnd ^ neg_dvsr) ? (~q_reg + ONE) : q_reg);
    r_fix   = dz ? dvnd_orig : (neg_dvnd ? (~r_reg + ONE) : r_reg);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dvsr_reg    <= '0;
      dvnd_orig   <= '0;
      neg_dvnd    <= 1'b0;
      neg_dvsr    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg     <= dividend;
            dvsr_reg  <= divisor;
            dvnd_orig <= dividend;
            neg_dvnd  <= is_signed & dividend[WIDTH-1];
            neg_dvsr  <= is_signed & divisor[WIDTH-1];
          end
        end
        PREP: begin
          if (neg_dvnd) q_reg    <= ~q_reg + ONE;
          if (neg_dvsr) dvsr_reg <= ~dvsr_reg + ONE;
          r_reg <= '0;
          cnt   <= CW'(WIDTH - 1);
        end
        ITER: begin
          r_reg <= r_step;
          q_reg <= {q_reg[WIDTH-2:0], r_ge};
          cnt   <= cnt - CW'(1);
        end
        // Divide-by-zero bypasses sign restoration: all-ones quotient, untouched dividend.
        FIXUP: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and random checks of iterative_divider against a queued scoreboard of expected results.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend, divisor;
  logic        busy, done;
  logic [63:0] quotient, remainder;
  logic        div_by_zero;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;

  iterative_divider #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.dz = 1'b0;
    if (b == 64'd0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
      e.q = a; e.r = 64'd0;
    end else if (sgn) begin
      e.q = 64'($signed(a) / $signed(b));
      e.r = 64'($signed(a) % $signed(b));
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  // Called at a negedge; start is seen by the next rising edge (cycle 0), returns in cycle 1.
  task automatic launch(input logic sgn, input logic [63:0] a, input logic [63:0] b, input exp_t e);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 is the current cycle index relative to the accepting edge; returns in the done cycle.
  task automatic wait_done(input int n0, input string tag);
    int   n = n0;
    exp_t e;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd67);
    if (done === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      last_exp = e;
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
    end
  endtask

  // Moves to the first IDLE cycle after DONE and checks the pulse ended with results held.
  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_q_held"}, quotient, last_exp.q);
  endtask

  task automatic run(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                     input exp_t e, input string tag);
    launch(sgn, a, b, e);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(1, tag);
    after_done(tag);
  endtask

  initial begin
    int dones;
    logic [63:0] ra, rb;
    logic        rs;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run(1'b1, 64'd100, 64'd7, '{64'd14, 64'd2, 1'b0}, "s100_7");
    run(1'b1, -64'sd100, 64'd7, '{64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0}, "sm100_7");
    run(1'b1, 64'd100, -64'sd7, '{64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0}, "s100_m7");
    run(1'b0, '1, 64'd2, '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0}, "u_max_2");
    run(1'b1, '1, 64'd2, '{64'd0, '1, 1'b0}, "s_m1_2");
    run(1'b1, 64'd100, 64'd0, '{'1, 64'd100, 1'b1}, "s100_0");
    run(1'b1, -64'sd100, 64'd0, '{'1, -64'sd100, 1'b1}, "sm100_0");
    run(1'b1, 64'h8000_0000_0000_0000, '1, '{64'h8000_0000_0000_0000, 64'd0, 1'b0}, "s_min_m1");
    run(1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFE, '{64'd1, 64'd1, 1'b0}, "u_max_big");

    // Start during an active divide and in the DONE cycle must be ignored.
    launch(1'b1, 64'd1000, 64'd10, '{64'd100, 64'd0, 1'b0});
    repeat (29) @(negedge clk);
    is_signed = 1'b0; dividend = 64'd77; divisor = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore_busy", 64'(busy), 64'd1);
    wait_done(31, "busy_ignore");
    is_signed = 1'b0; dividend = 64'd5; divisor = 64'd5; start = 1'b1;
    after_done("busy_ignore");
    dividend = 64'd50; divisor = 64'd8;
    launch(1'b0, 64'd50, 64'd8, '{64'd6, 64'd2, 1'b0});
    wait_done(1, "accept_68");
    after_done("accept_68");

    // Asynchronous reset mid-operation.
    launch(1'b1, -64'sd12345, 64'd17, model(1'b1, -64'sd12345, 64'd17));
    repeat (39) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_q", quotient, 64'd0);
    check("arst_r", remainder, 64'd0);
    check("arst_dz", 64'(div_by_zero), 64'd0);
    void'(sbq.pop_back());
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    run(1'b0, 64'd9, 64'd3, '{64'd3, 64'd0, 1'b0}, "post_rst_9_3");

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
      if (i == 3) rb = -64'sd3;
      run(rs, ra, rb, model(rs, ra, rb), $sformatf("rand%0d", i));
    end

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
